bcd_time_counter: RTL and testbench
===================================

// Module: bcd_time_counter
// PURPOSE
//   Time-of-day register stage for the alarm clock: HH:MM in BCD (24 h).
//   - Keeps seconds; consumes a 1 Hz tick.
//   - Increments its digits through ripple-carry adder logic.
//   - Provides button-driven set modes.
//   - Raises a one-cycle alarm pulse on a minute rollover that matches alarm time.
//   - Feeds the display and the alarm-control FSM.
// PARAMETERS
//   SEC_PER_MIN  60  ticks per minute; reduced in simulation to speed rollover (>=2)
// PORTS
//   clk        in   1   system clock; all state updates on posedge
//   rst        in   1   synchronous, active-high reset
//   tick       in   1   1 Hz enable, single-cycle pulse
//   mode_btn   in   1   debounced single-cycle pulse; advances set mode
//   inc_btn    in   1   debounced single-cycle pulse; increments selected field
//   alarm_en   in   1   alarm armed
//   alarm_bcd  in   16  {hr_t,hr_o,min_t,min_o} alarm time, BCD
//   time_bcd   out  16  {hr_t,hr_o,min_t,min_o} current time, BCD, registered
//   sec_cnt    out  6   seconds within minute, binary 0..SEC_PER_MIN-1
//   mode       out  2   00 RUN, 01 SET_HR, 10 SET_MIN (11 unused)
//   min_pulse  out  1   one-cycle pulse, coincident with minute-rollover update
//   alarm_hit  out  1   one-cycle pulse, see below
// BEHAVIOUR
//   Reset
//     - rst=1 at posedge: mode=RUN, time_bcd=16'h0000, sec_cnt=0, min_pulse=0, alarm_hit=0.
//     - Reset overrides every other input, including mid-set or mid-rollover.
//   Timing
//     - All outputs are registered.
//     - An input sampled at edge N shows its effect after edge N (latency 1 cycle).
//   State machine on mode_btn
//     - RUN -> SET_HR -> SET_MIN -> RUN.
//     - Any transition into SET_HR forces sec_cnt=0.
//     - mode value 11 is unreachable; if it is ever decoded, go to RUN.
//   RUN, on tick
//     - sec_cnt+1.
//     - If sec_cnt==SEC_PER_MIN-1: sec_cnt=0, minutes+1, min_pulse=1 in the same cycle.
//     - Minutes 59 -> 00 carries into hours; hours 23 -> 00 wraps (23:59 -> 00:00).
//     - BCD digit rules: ones 9 -> 0 carries into tens; min_t 0..5; hr 00..23.
//   RUN: inc_btn is ignored.
//   SET_HR / SET_MIN
//     - tick is ignored; sec_cnt holds at 0; min_pulse and alarm_hit stay 0.
//     - SET_HR, on inc_btn: hours+1, 23 -> 00; minutes unchanged.
//     - SET_MIN, on inc_btn: minutes+1, 59 -> 00; no carry into hours.
//   alarm_hit
//     - Asserted with min_pulse when, in RUN, alarm_en=1 and the new time_bcd==alarm_bcd.
//     - Never asserted by set-mode edits.
//     - A non-BCD alarm_bcd never matches.
//   Simultaneous events
//     - mode_btn+inc_btn: mode_btn wins; inc_btn is dropped.
//     - RUN with tick+mode_btn: the tick's minute/hour carry is applied, min_pulse and
//       alarm_hit follow the RUN rules, then mode=SET_HR and sec_cnt=0.
//     - tick during a set mode is lost; it is not queued.
// TESTING
//   1. rst=1 for 2 cycles with tick and buttons toggling -> time_bcd=0000, sec_cnt=0,
//      mode=00, both pulses 0.
//   2. SEC_PER_MIN=4, preset 23:59, 4 ticks -> time_bcd=16'h0000; min_pulse for exactly
//      1 cycle after 4th tick.
//   3. 09:59 rollover -> 10:00; 19:59 -> 20:00; 00:09 -> 00:10 (BCD digit carry checks).
//   4. mode_btn, 25x inc_btn -> hours 01, minutes unchanged; mode_btn, 61x inc_btn ->
//      minutes 01, hours 01; mode_btn -> mode=00.
//   5. alarm_bcd=16'h0700, alarm_en=1, rollover 06:59 -> 07:00 -> alarm_hit 1 cycle;
//      repeat with alarm_en=0 -> 0; set minutes to 00 at 07 -> no hit.
//   6. Edge cases:
//      - RUN, tick+mode_btn same cycle at sec_cnt=SEC_PER_MIN-1 -> minutes+1, mode=01, sec_cnt=0.
//      - mode_btn+inc_btn same cycle -> mode advances, value unchanged.
//      - rst mid-SET_MIN -> RUN, 00:00.

Source files
------------

// File: rtl/bcd_time_counter.sv
// Time-of-day register stage: BCD HH:MM (24 h) with a seconds counter, set modes
// and a one-cycle alarm pulse on a minute rollover that matches the alarm time.
module bcd_time_counter #(
  parameter int SEC_PER_MIN = 60
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        mode_btn_i,
  input  logic        inc_btn_i,
  input  logic        alarm_en_i,
  input  logic [15:0] alarm_bcd_i,
  output logic [15:0] time_bcd_o,
  output logic [5:0]  sec_cnt_o,
  output logic [1:0]  mode_o,
  output logic        min_pulse_o,
  output logic        alarm_hit_o
);

  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_SET_HR  = 2'b01;
  localparam logic [1:0] MODE_SET_MIN = 2'b10;

  localparam logic [5:0] SEC_LAST = 6'(SEC_PER_MIN - 1);

  logic [1:0]  mode_q,     mode_d;
  logic [7:0]  hours_q,    hours_d;
  logic [7:0]  minutes_q,  minutes_d;
  logic [5:0]  sec_q,      sec_d;
  logic        minPulse_q, minPulse_d;
  logic        alarmHit_q, alarmHit_d;

  logic [8:0]  minInc;
  logic [7:0]  hrInc;
  logic [8:0]  minWrap;
  logic [7:0]  hrWrap;
  logic [15:0] rolledTime;
  logic        alarmValid;

  // 4-bit ripple-carry adder built from explicit full-adder stages
  function automatic logic [4:0] rippleAdd4(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin);
    logic       c;
    logic [3:0] s;
    c = cin;
    s = 4'd0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {c, s};
  endfunction

  // One BCD digit: adds cin and wraps to zero past maxDigit, returning {carry, digit}
  function automatic logic [4:0] bcdDigitInc(input logic [3:0] d, input logic cin,
                                            input logic [3:0] maxDigit);
    logic [4:0] sum;
    sum = rippleAdd4(d, 4'd0, cin);
    if (cin && (d == maxDigit)) begin
      return {1'b1, 4'd0};
    end
    return {1'b0, sum[3:0]};
  endfunction

  function automatic logic [8:0] minutesInc(input logic [7:0] m, input logic cin);
    logic [4:0] ones;
    logic [4:0] tens;
    ones = bcdDigitInc(m[3:0], cin, 4'd9);
    tens = bcdDigitInc(m[7:4], ones[4], 4'd5);
    return {tens[4], tens[3:0], ones[3:0]};
  endfunction

  // Hours wrap at 23 rather than at a digit boundary, so the tens digit never carries
  function automatic logic [7:0] hoursInc(input logic [7:0] h, input logic cin);
    logic [4:0] ones;
    logic [4:0] tens;
    if (cin && (h == 8'h23)) begin
      return 8'h00;
    end
    ones = bcdDigitInc(h[3:0], cin, 4'd9);
    tens = bcdDigitInc(h[7:4], ones[4], 4'd9);
    return {tens[3:0], ones[3:0]};
  endfunction

  function automatic logic isValidTime(input logic [15:0] t);
    logic ok;
    ok = (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) && (t[11:8] <= 4'd9) && (t[15:12] <= 4'd2);
    if (t[15:12] == 4'd2) begin
      ok = ok && (t[11:8] <= 4'd3);
    end
    return ok;
  endfunction

  always_comb begin
    minInc     = minutesInc(minutes_q, 1'b1);
    hrInc      = hoursInc(hours_q, minInc[8]);
    minWrap    = minutesInc(minutes_q, 1'b1);
    hrWrap     = hoursInc(hours_q, 1'b1);
    rolledTime = {hrInc, minInc[7:0]};
    alarmValid = isValidTime(alarm_bcd_i);
  end

  always_comb begin
    mode_d     = mode_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    sec_d      = sec_q;
    minPulse_d = 1'b0;
    alarmHit_d = 1'b0;

    case (mode_q)
      MODE_RUN: begin
        if (tick_i) begin
          if (sec_q == SEC_LAST) begin
            sec_d      = 6'd0;
            minutes_d  = minInc[7:0];
            hours_d    = hrInc;
            minPulse_d = 1'b1;
            alarmHit_d = alarm_en_i && alarmValid && (rolledTime == alarm_bcd_i);
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        // A simultaneous mode press still lets the tick's carry and pulses land
        if (mode_btn_i) begin
          mode_d = MODE_SET_HR;
          sec_d  = 6'd0;
        end
      end

      MODE_SET_HR: begin
        sec_d = 6'd0;
        if (mode_btn_i) begin
          mode_d = MODE_SET_MIN;
        end else if (inc_btn_i) begin
          hours_d = hrWrap;
        end
      end

      MODE_SET_MIN: begin
        sec_d = 6'd0;
        if (mode_btn_i) begin
          mode_d = MODE_RUN;
        end else if (inc_btn_i) begin
          minutes_d = minWrap[7:0];
        end
      end

      default: begin
        mode_d = MODE_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= MODE_RUN;
      hours_q    <= 8'h00;
      minutes_q  <= 8'h00;
      sec_q      <= 6'd0;
      minPulse_q <= 1'b0;
      alarmHit_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      sec_q      <= sec_d;
      minPulse_q <= minPulse_d;
      alarmHit_q <= alarmHit_d;
    end
  end

  assign time_bcd_o  = {hours_q, minutes_q};
  assign sec_cnt_o   = sec_q;
  assign mode_o      = mode_q;
  assign min_pulse_o = minPulse_q;
  assign alarm_hit_o = alarmHit_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter: directed scenarios plus random stimulus,
// all compared each cycle against an integer-arithmetic model of the clock.
module tb_bcd_time_counter;

  localparam int SPM = 4;

  logic        clk = 1'b0;
  logic        rst, tick, modeBtn, incBtn, alarmEn;
  logic [15:0] alarmBcd;
  logic [15:0] timeBcd;
  logic [5:0]  secCnt;
  logic [1:0]  mode;
  logic        minPulse, alarmHit;

  int nAsserts = 0;
  int nFails   = 0;

  int mHours = 0, mMins = 0, mSec = 0, mMode = 0;
  logic mPulse = 1'b0, mHit = 1'b0;

  bcd_time_counter #(.SEC_PER_MIN(SPM)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .mode_btn_i  (modeBtn),
    .inc_btn_i   (incBtn),
    .alarm_en_i  (alarmEn),
    .alarm_bcd_i (alarmBcd),
    .time_bcd_o  (timeBcd),
    .sec_cnt_o   (secCnt),
    .mode_o      (mode),
    .min_pulse_o (minPulse),
    .alarm_hit_o (alarmHit)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  // Model of one clock edge, written in terms of total minutes of the day
  task automatic modelStep(input logic r, input logic t, input logic mb, input logic ib);
    int total;
    mPulse = 1'b0;
    mHit   = 1'b0;
    if (r) begin
      mHours = 0; mMins = 0; mSec = 0; mMode = 0;
    end else if (mMode == 0) begin
      if (t) begin
        mSec++;
        if (mSec == SPM) begin
          mSec   = 0;
          total  = (mHours * 60 + mMins + 1) % 1440;
          mHours = total / 60;
          mMins  = total % 60;
          mPulse = 1'b1;
          mHit   = alarmEn && (alarmBcd == toBcd(mHours, mMins));
        end
      end
      if (mb) begin
        mMode = 1;
        mSec  = 0;
      end
    end else if (mMode == 1) begin
      if (mb) mMode = 2;
      else if (ib) mHours = (mHours + 1) % 24;
    end else begin
      if (mb) mMode = 0;
      else if (ib) mMins = (mMins + 1) % 60;
    end
  endtask

  task automatic checkOutput();
    nAsserts++;
    assert (timeBcd === toBcd(mHours, mMins)) else begin
      nFails++;
      $error("FAIL time_bcd: observed %h expected %h", timeBcd, toBcd(mHours, mMins));
    end
    nAsserts++;
    assert (secCnt === 6'(mSec)) else begin
      nFails++;
      $error("FAIL sec_cnt: observed %0d expected %0d", secCnt, mSec);
    end
    nAsserts++;
    assert (mode === 2'(mMode)) else begin
      nFails++;
      $error("FAIL mode: observed %b expected %b", mode, 2'(mMode));
    end
    nAsserts++;
    assert (minPulse === mPulse) else begin
      nFails++;
      $error("FAIL min_pulse: observed %b expected %b", minPulse, mPulse);
    end
    nAsserts++;
    assert (alarmHit === mHit) else begin
      nFails++;
      $error("FAIL alarm_hit: observed %b expected %b", alarmHit, mHit);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic mb, input logic ib);
    rst = r; tick = t; modeBtn = mb; incBtn = ib;
    @(posedge clk);
    #1;
    modelStep(r, t, mb, ib);
    checkOutput();
    rst = 1'b0; tick = 1'b0; modeBtn = 1'b0; incBtn = 1'b0;
  endtask

  // Presets the time through the set modes, ending back in RUN with sec_cnt=0
  task automatic setTime(input int h, input int m);
    int guard;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (mHours != h && guard < 30) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (mMins != m && guard < 70) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic tickMinute();
    for (int i = 0; i < SPM; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; modeBtn = 1'b0; incBtn = 1'b0;
    alarmEn = 1'b0; alarmBcd = 16'h0000;

    $display("[TB] reset with inputs toggling");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);

    $display("[TB] 23:59 wraps to 00:00");
    setTime(23, 59);
    tickMinute();

    $display("[TB] BCD digit carries");
    setTime(9, 59);  tickMinute();
    setTime(19, 59); tickMinute();
    setTime(0, 9);   tickMinute();

    $display("[TB] set modes with wrap-around");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 61; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] alarm match, disabled, and set-mode edit");
    alarmBcd = 16'h0700;
    alarmEn  = 1'b1;
    setTime(6, 59); tickMinute();
    alarmEn  = 1'b0;
    setTime(6, 59); tickMinute();
    alarmEn  = 1'b1;
    setTime(7, 59);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    alarmBcd = 16'h07AF;
    setTime(7, 59); tickMinute();

    $display("[TB] simultaneous events");
    alarmBcd = 16'h1235;
    setTime(12, 34);
    for (int i = 0; i < SPM - 1; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] random stimulus");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        alarmEn = 1'($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 2))
          0: alarmBcd = toBcd(((mHours * 60 + mMins + 1) % 1440) / 60,
                              ((mHours * 60 + mMins + 1) % 1440) % 60);
          1: alarmBcd = 16'($urandom);
          default: alarmBcd = toBcd(mHours, mMins);
        endcase
      end
      applyStimulus(1'($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 11) == 0),
                    1'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
